coz_kuyruk: RTL and testbench

COZ_KUYRUK -- requirements
Module: coz_kuyruk

---
 rtl/coz_kuyruk.sv | 200 ++++++++++++++++++++
 tb/tb_coz_kuyruk.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/coz_kuyruk.sv
// Fetch-to-decode queue: buffers fetched instructions in a small FIFO and
// decodes the head into a registered uop stream with a rolling tag.
module coz_kuyruk #(
    parameter int KUYRUK_DERINLIK = 4,
    parameter int ETIKET_BIT      = 4,
    parameter int CSR_EN          = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  bosalt_i,
    input  logic                  getir_gecerli_i,
    output logic                  getir_hazir_o,
    input  logic [31:0]           getir_buyruk_i,
    input  logic [31:0]           getir_ps_i,
    input  logic                  getir_atladi_i,
    output logic                  yo_gecerli_o,
    input  logic                  yo_hazir_i,
    output logic [31:0]           yo_ps_o,
    output logic                  yo_atladi_o,
    output logic [ETIKET_BIT-1:0] yo_etiket_o,
    output logic [4:0]            yo_islem_o,
    output logic [4:0]            yo_rs1_o,
    output logic [4:0]            yo_rs2_o,
    output logic [4:0]            yo_rd_o,
    output logic                  yo_rs1_en_o,
    output logic                  yo_rs2_en_o,
    output logic                  yo_rd_en_o,
    output logic [31:0]           yo_imm_o,
    output logic [11:0]           yo_csr_o,
    output logic                  yo_csr_en_o,
    output logic                  yo_gecersiz_o
);
    localparam int AW = $clog2(KUYRUK_DERINLIK);
    localparam logic [AW:0]           PTR_BIR    = 1;
    localparam logic [ETIKET_BIT-1:0] ETIKET_BIR = 1;

    localparam logic [4:0] I_NOP = 5'd0,  I_LUI = 5'd1,  I_AUIPC = 5'd2, I_JAL = 5'd3,
                           I_JALR = 5'd4, I_BEQ = 5'd5,  I_BNE = 5'd6,   I_BLT = 5'd7,
                           I_LW = 5'd8,   I_SW = 5'd9,   I_ADDI = 5'd10, I_ADD = 5'd11,
                           I_SUB = 5'd12, I_AND = 5'd13, I_OR = 5'd14,   I_XOR = 5'd15,
                           I_CSRRW = 5'd16;

    logic [31:0] mem_buyruk [KUYRUK_DERINLIK];
    logic [31:0] mem_ps     [KUYRUK_DERINLIK];
    logic        mem_atladi [KUYRUK_DERINLIK];
    logic [AW:0] yaz_ptr, oku_ptr;
    logic [ETIKET_BIT-1:0] etiket_sayac;

    logic bos, dolu, it, yukle;

    assign bos   = (yaz_ptr == oku_ptr);
    assign dolu  = (yaz_ptr[AW] != oku_ptr[AW]) && (yaz_ptr[AW-1:0] == oku_ptr[AW-1:0]);
    assign getir_hazir_o = !dolu;
    assign it    = getir_gecerli_i && !dolu && !bosalt_i;
    assign yukle = !bos && (!yo_gecerli_o || yo_hazir_i) && !bosalt_i;

    always_ff @(posedge clk_i) begin
        if (it) begin
            mem_buyruk[yaz_ptr[AW-1:0]] <= getir_buyruk_i;
            mem_ps[yaz_ptr[AW-1:0]]     <= getir_ps_i;
            mem_atladi[yaz_ptr[AW-1:0]] <= getir_atladi_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            yaz_ptr <= '0;
            oku_ptr <= '0;
        end else if (bosalt_i) begin
            oku_ptr <= yaz_ptr;
        end else begin
            if (it)    yaz_ptr <= yaz_ptr + PTR_BIR;
            if (yukle) oku_ptr <= oku_ptr + PTR_BIR;
        end
    end

    // Head decode
    logic [31:0] b;
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  d_islem;
    logic        d_rs1_en, d_rs2_en, d_rd_yazar, d_csr_en, d_gecersiz;
    logic [31:0] d_imm;

    assign b   = mem_buyruk[oku_ptr[AW-1:0]];
    assign opc = b[6:0];
    assign f3  = b[14:12];
    assign f7  = b[31:25];

    always_comb begin
        d_islem    = I_NOP;
        d_rs1_en   = 1'b0;
        d_rs2_en   = 1'b0;
        d_rd_yazar = 1'b0;
        d_csr_en   = 1'b0;
        d_gecersiz = 1'b0;
        d_imm      = '0;
        case (opc)
            7'b0110111: begin d_islem = I_LUI;   d_rd_yazar = 1'b1; d_imm = {b[31:12], 12'b0}; end
            7'b0010111: begin d_islem = I_AUIPC; d_rd_yazar = 1'b1; d_imm = {b[31:12], 12'b0}; end
            7'b1101111: begin
                d_islem = I_JAL; d_rd_yazar = 1'b1;
                d_imm = {{11{b[31]}}, b[31], b[19:12], b[20], b[30:21], 1'b0};
            end
            7'b1100111: if (f3 == 3'b000) begin
                d_islem = I_JALR; d_rs1_en = 1'b1; d_rd_yazar = 1'b1;
                d_imm = {{20{b[31]}}, b[31:20]};
            end else d_gecersiz = 1'b1;
            7'b1100011: begin
                d_rs1_en = 1'b1; d_rs2_en = 1'b1;
                d_imm = {{19{b[31]}}, b[31], b[7], b[30:25], b[11:8], 1'b0};
                case (f3)
                    3'b000:  d_islem = I_BEQ;
                    3'b001:  d_islem = I_BNE;
                    3'b100:  d_islem = I_BLT;
                    default: d_gecersiz = 1'b1;
                endcase
            end
            7'b0000011: if (f3 == 3'b010) begin
                d_islem = I_LW; d_rs1_en = 1'b1; d_rd_yazar = 1'b1;
                d_imm = {{20{b[31]}}, b[31:20]};
            end else d_gecersiz = 1'b1;
            7'b0100011: if (f3 == 3'b010) begin
                d_islem = I_SW; d_rs1_en = 1'b1; d_rs2_en = 1'b1;
                d_imm = {{20{b[31]}}, b[31:25], b[11:7]};
            end else d_gecersiz = 1'b1;
            7'b0010011: if (f3 == 3'b000) begin
                d_islem = I_ADDI; d_rs1_en = 1'b1; d_rd_yazar = 1'b1;
                d_imm = {{20{b[31]}}, b[31:20]};
            end else d_gecersiz = 1'b1;
            7'b0110011: begin
                d_rs1_en = 1'b1; d_rs2_en = 1'b1; d_rd_yazar = 1'b1;
                case ({f7, f3})
                    10'b0000000_000: d_islem = I_ADD;
                    10'b0100000_000: d_islem = I_SUB;
                    10'b0000000_111: d_islem = I_AND;
                    10'b0000000_110: d_islem = I_OR;
                    10'b0000000_100: d_islem = I_XOR;
                    default:         d_gecersiz = 1'b1;
                endcase
            end
            7'b1110011: if (CSR_EN != 0 && f3 == 3'b001) begin
                d_islem = I_CSRRW; d_rs1_en = 1'b1; d_rd_yazar = 1'b1; d_csr_en = 1'b1;
            end else d_gecersiz = 1'b1;
            default: d_gecersiz = 1'b1;
        endcase
        // Illegal uops must not carry any operand or write enables.
        if (d_gecersiz) begin
            d_islem    = I_NOP;
            d_rs1_en   = 1'b0;
            d_rs2_en   = 1'b0;
            d_rd_yazar = 1'b0;
            d_csr_en   = 1'b0;
            d_imm      = '0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            yo_gecerli_o  <= 1'b0;
            etiket_sayac  <= '0;
            yo_ps_o       <= '0;
            yo_atladi_o   <= 1'b0;
            yo_etiket_o   <= '0;
            yo_islem_o    <= '0;
            yo_rs1_o      <= '0;
            yo_rs2_o      <= '0;
            yo_rd_o       <= '0;
            yo_rs1_en_o   <= 1'b0;
            yo_rs2_en_o   <= 1'b0;
            yo_rd_en_o    <= 1'b0;
            yo_imm_o      <= '0;
            yo_csr_o      <= '0;
            yo_csr_en_o   <= 1'b0;
            yo_gecersiz_o <= 1'b0;
        end else if (bosalt_i) begin
            yo_gecerli_o <= 1'b0;
        end else if (yukle) begin
            yo_gecerli_o  <= 1'b1;
            etiket_sayac  <= etiket_sayac + ETIKET_BIR;
            yo_etiket_o   <= etiket_sayac;
            yo_ps_o       <= mem_ps[oku_ptr[AW-1:0]];
            yo_atladi_o   <= mem_atladi[oku_ptr[AW-1:0]];
            yo_islem_o    <= d_islem;
            yo_rs1_o      <= b[19:15];
            yo_rs2_o      <= b[24:20];
            yo_rd_o       <= b[11:7];
            yo_rs1_en_o   <= d_rs1_en;
            yo_rs2_en_o   <= d_rs2_en;
            yo_rd_en_o    <= d_rd_yazar && (b[11:7] != 5'd0);
            yo_imm_o      <= d_imm;
            yo_csr_o      <= d_csr_en ? b[31:20] : 12'd0;
            yo_csr_en_o   <= d_csr_en;
            yo_gecersiz_o <= d_gecersiz;
        end else if (yo_hazir_i) begin
            yo_gecerli_o <= 1'b0;
        end
    end
endmodule

// File: tb/tb_coz_kuyruk.sv
// Directed bench for coz_kuyruk: decode, backpressure, streaming, flush and reset.
module tb_coz_kuyruk;
    logic        clk = 1'b0, rst = 1'b0, bosalt = 1'b0;
    logic        getir_gecerli = 1'b0, getir_atladi = 1'b0, yo_hazir = 1'b0;
    logic [31:0] getir_buyruk = '0, getir_ps = '0;
    logic        getir_hazir, yo_gecerli, yo_atladi;
    logic [31:0] yo_ps, yo_imm;
    logic [3:0]  yo_etiket;
    logic [4:0]  yo_islem, yo_rs1, yo_rs2, yo_rd;
    logic        yo_rs1_en, yo_rs2_en, yo_rd_en, yo_csr_en, yo_gecersiz;
    logic [11:0] yo_csr;

    logic        c0_getir_hazir, c0_gecerli, c0_atladi;
    logic [31:0] c0_ps, c0_imm;
    logic [3:0]  c0_etiket;
    logic [4:0]  c0_islem, c0_rs1, c0_rs2, c0_rd;
    logic        c0_rs1_en, c0_rs2_en, c0_rd_en, c0_csr_en, c0_gecersiz;
    logic [11:0] c0_csr;

    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    coz_kuyruk #(.KUYRUK_DERINLIK(4), .ETIKET_BIT(4), .CSR_EN(1)) dut (
        .clk_i(clk), .rst_i(rst), .bosalt_i(bosalt),
        .getir_gecerli_i(getir_gecerli), .getir_hazir_o(getir_hazir),
        .getir_buyruk_i(getir_buyruk), .getir_ps_i(getir_ps), .getir_atladi_i(getir_atladi),
        .yo_gecerli_o(yo_gecerli), .yo_hazir_i(yo_hazir), .yo_ps_o(yo_ps),
        .yo_atladi_o(yo_atladi), .yo_etiket_o(yo_etiket), .yo_islem_o(yo_islem),
        .yo_rs1_o(yo_rs1), .yo_rs2_o(yo_rs2), .yo_rd_o(yo_rd),
        .yo_rs1_en_o(yo_rs1_en), .yo_rs2_en_o(yo_rs2_en), .yo_rd_en_o(yo_rd_en),
        .yo_imm_o(yo_imm), .yo_csr_o(yo_csr), .yo_csr_en_o(yo_csr_en),
        .yo_gecersiz_o(yo_gecersiz)
    );

    coz_kuyruk #(.KUYRUK_DERINLIK(4), .ETIKET_BIT(4), .CSR_EN(0)) dut_csr0 (
        .clk_i(clk), .rst_i(rst), .bosalt_i(bosalt),
        .getir_gecerli_i(getir_gecerli), .getir_hazir_o(c0_getir_hazir),
        .getir_buyruk_i(getir_buyruk), .getir_ps_i(getir_ps), .getir_atladi_i(getir_atladi),
        .yo_gecerli_o(c0_gecerli), .yo_hazir_i(yo_hazir), .yo_ps_o(c0_ps),
        .yo_atladi_o(c0_atladi), .yo_etiket_o(c0_etiket), .yo_islem_o(c0_islem),
        .yo_rs1_o(c0_rs1), .yo_rs2_o(c0_rs2), .yo_rd_o(c0_rd),
        .yo_rs1_en_o(c0_rs1_en), .yo_rs2_en_o(c0_rs2_en), .yo_rd_en_o(c0_rd_en),
        .yo_imm_o(c0_imm), .yo_csr_o(c0_csr), .yo_csr_en_o(c0_csr_en),
        .yo_gecersiz_o(c0_gecersiz)
    );

    task automatic kontrol(input string ad, input logic [31:0] gozlenen, input logic [31:0] beklenen);
        checks++;
        if (gozlenen !== beklenen) begin
            errors++;
            $display("FAIL %s: got %h expected %h", ad, gozlenen, beklenen);
        end
    endtask

    task automatic tik();
        @(posedge clk);
        #1;
    endtask

    task automatic sifirla();
        getir_gecerli = 1'b0;
        bosalt = 1'b0;
        rst = 1'b1;
        tik();
        rst = 1'b0;
    endtask

    logic [31:0] p_buyruk [5] = '{32'h123451B7, 32'hFE20AE23, 32'h409403B3, 32'hFE208CE3, 32'h010000EF};
    logic [4:0]  p_islem  [5] = '{5'd1, 5'd9, 5'd12, 5'd5, 5'd3};
    logic [31:0] p_imm    [5] = '{32'h12345000, 32'hFFFFFFFC, 32'h0, 32'hFFFFFFF8, 32'h10};

    initial begin
        // Reset state
        rst = 1'b1;
        #2;
        kontrol("rst_gecerli", yo_gecerli, 0);
        kontrol("rst_hazir", getir_hazir, 1);
        kontrol("rst_ps", yo_ps, 0);
        kontrol("rst_islem", yo_islem, 0);
        tik();
        rst = 1'b0;

        // Single ADDI, two-edge latency
        yo_hazir = 1'b1;
        getir_gecerli = 1'b1; getir_buyruk = 32'hFFD08293; getir_ps = 32'h100; getir_atladi = 1'b1;
        tik();
        kontrol("addi_lat1", yo_gecerli, 0);
        getir_gecerli = 1'b0; getir_atladi = 1'b0;
        tik();
        kontrol("addi_gecerli", yo_gecerli, 1);
        kontrol("addi_islem", yo_islem, 10);
        kontrol("addi_rs1", yo_rs1, 1);
        kontrol("addi_rs1_en", yo_rs1_en, 1);
        kontrol("addi_rs2_en", yo_rs2_en, 0);
        kontrol("addi_rd", yo_rd, 5);
        kontrol("addi_rd_en", yo_rd_en, 1);
        kontrol("addi_imm", yo_imm, 32'hFFFFFFFD);
        kontrol("addi_etiket", yo_etiket, 0);
        kontrol("addi_ps", yo_ps, 32'h100);
        kontrol("addi_atladi", yo_atladi, 1);
        tik();
        kontrol("addi_bosalir", yo_gecerli, 0);

        // Backpressure: 5 accepted with depth 4, then full and stable
        sifirla();
        yo_hazir = 1'b0;
        for (int k = 0; k < 5; k++) begin
            getir_gecerli = 1'b1; getir_buyruk = p_buyruk[k]; getir_ps = 32'h200 + 32'(4 * k);
            tik();
        end
        kontrol("bp_dolu", getir_hazir, 0);
        kontrol("bp_gecerli", yo_gecerli, 1);
        getir_buyruk = 32'h00000013; getir_ps = 32'hDEAD;
        tik();
        tik();
        kontrol("bp_dolu2", getir_hazir, 0);
        kontrol("bp_stabil_ps", yo_ps, 32'h200);
        kontrol("bp_stabil_etiket", yo_etiket, 0);
        kontrol("bp_islem0", yo_islem, p_islem[0]);
        kontrol("bp_imm0", yo_imm, p_imm[0]);
        kontrol("bp_rd0", yo_rd, 3);
        getir_gecerli = 1'b0; yo_hazir = 1'b1;
        for (int k = 1; k < 5; k++) begin
            tik();
            kontrol("bp_gecerli_k", yo_gecerli, 1);
            kontrol("bp_etiket_k", yo_etiket, k);
            kontrol("bp_ps_k", yo_ps, 32'h200 + 32'(4 * k));
            kontrol("bp_islem_k", yo_islem, p_islem[k]);
            kontrol("bp_imm_k", yo_imm, p_imm[k]);
            if (k == 1) begin
                kontrol("sw_rs2_en", yo_rs2_en, 1);
                kontrol("sw_rd_en", yo_rd_en, 0);
            end
        end
        tik();
        kontrol("bp_son", yo_gecerli, 0);

        // Back-to-back stream of 20, tags wrap at 16
        sifirla();
        yo_hazir = 1'b1;
        for (int c = 0; c <= 20; c++) begin
            getir_gecerli = (c < 20);
            getir_buyruk = 32'h00000013;
            getir_ps = 32'(c * 4);
            tik();
            if (c == 0) kontrol("akis_lat", yo_gecerli, 0);
            else begin
                kontrol("akis_gecerli", yo_gecerli, 1);
                kontrol("akis_etiket", yo_etiket, (c - 1) % 16);
                kontrol("akis_ps", yo_ps, 32'((c - 1) * 4));
            end
        end
        getir_gecerli = 1'b0;
        tik();
        kontrol("akis_son", yo_gecerli, 0);

        // Flush with 3 queued and output valid
        sifirla();
        yo_hazir = 1'b0;
        for (int k = 0; k < 4; k++) begin
            getir_gecerli = 1'b1; getir_buyruk = 32'h00000013; getir_ps = 32'(k);
            tik();
        end
        kontrol("fl_once", yo_gecerli, 1);
        bosalt = 1'b1; getir_ps = 32'h99;
        tik();
        kontrol("fl_gecerli", yo_gecerli, 0);
        kontrol("fl_hazir", getir_hazir, 1);
        bosalt = 1'b0; getir_gecerli = 1'b0; yo_hazir = 1'b1;
        tik();
        kontrol("fl_bos", yo_gecerli, 0);
        getir_gecerli = 1'b1; getir_ps = 32'h300;
        tik();
        getir_gecerli = 1'b0;
        tik();
        kontrol("fl_sonra_gecerli", yo_gecerli, 1);
        kontrol("fl_sonra_etiket", yo_etiket, 1);
        kontrol("fl_sonra_ps", yo_ps, 32'h300);

        // Illegal all-zero and CSRRW with both CSR_EN settings
        sifirla();
        yo_hazir = 1'b1;
        getir_gecerli = 1'b1; getir_buyruk = 32'h00000000; getir_ps = 32'h400;
        tik();
        getir_buyruk = 32'h30009073; getir_ps = 32'h404;
        tik();
        getir_gecerli = 1'b0;
        kontrol("sifir_gecerli", yo_gecerli, 1);
        kontrol("sifir_gecersiz", yo_gecersiz, 1);
        kontrol("sifir_islem", yo_islem, 0);
        kontrol("sifir_rs1_en", yo_rs1_en, 0);
        kontrol("sifir_c0_gecersiz", c0_gecersiz, 1);
        tik();
        kontrol("csr_islem", yo_islem, 16);
        kontrol("csr_adres", yo_csr, 12'h300);
        kontrol("csr_en", yo_csr_en, 1);
        kontrol("csr_rd_en", yo_rd_en, 0);
        kontrol("csr_rs1_en", yo_rs1_en, 1);
        kontrol("csr_gecersiz", yo_gecersiz, 0);
        kontrol("csr_etiket", yo_etiket, 1);
        kontrol("c0_csr_gecerli", c0_gecerli, 1);
        kontrol("c0_csr_gecersiz", c0_gecersiz, 1);
        kontrol("c0_csr_islem", c0_islem, 0);
        kontrol("c0_csr_en", c0_csr_en, 0);

        // Asynchronous reset mid-stream
        sifirla();
        yo_hazir = 1'b0;
        for (int k = 0; k < 3; k++) begin
            getir_gecerli = 1'b1; getir_buyruk = 32'h00000013; getir_ps = 32'h500 + 32'(k);
            tik();
        end
        getir_gecerli = 1'b0;
        tik();
        kontrol("ar_once", yo_gecerli, 1);
        #3 rst = 1'b1;
        #1;
        kontrol("ar_gecerli", yo_gecerli, 0);
        kontrol("ar_hazir", getir_hazir, 1);
        kontrol("ar_ps", yo_ps, 0);
        #2 rst = 1'b0;
        yo_hazir = 1'b1;
        tik();
        kontrol("ar_fifo_bos", yo_gecerli, 0);
        getir_gecerli = 1'b1; getir_ps = 32'h600;
        tik();
        getir_gecerli = 1'b0;
        tik();
        kontrol("ar_sonra_gecerli", yo_gecerli, 1);
        kontrol("ar_sonra_etiket", yo_etiket, 0);
        kontrol("ar_sonra_ps", yo_ps, 32'h600);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
